// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   - prefix codes (extended, release, pause) and the pause skip length
//   - list of keyboard status/handshake codes that never become key events
//   - bit-level FSM state enum and the key event layout
package ps2_pkg;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_REL   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // bytes left in the Pause sequence after its leading E1
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int N_IGNORE = 6;
  localparam logic [N_IGNORE-1:0][7:0] IGNORE_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } bit_state_e;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORE; i++)
      if (IGNORE_CODES[i] == b) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_gen_if.sv
// ps2_key_gen_if: PS/2 line inputs plus decoded outputs of the key generator.
//   slave  : the decoder side (samples ps2 lines, drives key/byte/status)
//   master : the keyboard/host side (drives ps2 lines, observes results)
interface ps2_key_gen_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        frame_err;

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, rx_byte, rx_strobe, frame_err
  );

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, rx_byte, rx_strobe, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 serial frame receiver.
//   clk_sys, reset      : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   rx_byte, rx_strobe  : last good byte, one-cycle update pulse
//   frame_err           : one-cycle pulse on parity/stop/timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 49152
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          din;

  // Synchronisers reset high so a reset never fabricates a falling edge.
  // The filter only adopts a new level after FILTER_LEN consecutive
  // disagreeing samples; fall is registered alongside the level change.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign din = data_sync[1];

  bit_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo       <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (fall || state == ST_IDLE) tmo <= '0;
      else                          tmo <= tmo + TW'(1);

      if (state != ST_IDLE && !fall && tmo == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            // a high "start" bit is line noise, not an error
            if (!din) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= din;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (din && (^{shreg, par_bit})) begin
              rx_byte   <= shreg;
              rx_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_gen.sv
// ps2_key_gen: PS/2 keyboard front end producing toggle-style key events.
//   clk_sys, reset : system clock, synchronous active-high reset
//   bus (slave)    : ps2_clk/ps2_data in; ps2_key, rx_byte, rx_strobe,
//                    frame_err out
// ps2_key = {toggle, pressed, extended, scancode}; toggle flips once per event.
module ps2_key_gen
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 49152
) (
  input  logic        clk_sys,
  input  logic        reset,
  ps2_key_gen_if.slave bus
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame_rx (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err)
  );

  key_evt_t   key;
  logic       ext, rel;
  logic [2:0] skip;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key  <= '0;
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (frame_err) begin
      // a broken frame may have been a prefix; never let it leak forward
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (rx_strobe) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (rx_byte == CODE_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == CODE_REL) begin
        rel <= 1'b1;
      end else if (rx_byte == CODE_PAUSE) begin
        skip <= PAUSE_SKIP;
      end else if (ext || rel || !is_ignored(rx_byte)) begin
        // status codes are only dropped when no prefix is pending
        key <= '{toggle: ~key.toggle, pressed: ~rel, ext: ext, code: rx_byte};
        ext <= 1'b0;
        rel <= 1'b0;
      end
    end
  end

  assign bus.ps2_key   = key;
  assign bus.rx_byte   = rx_byte;
  assign bus.rx_strobe = rx_strobe;
  assign bus.frame_err = frame_err;

endmodule
